// File: rtl/clock_divider_bank_if.sv
// ---------------------------------------------------------------------------
// clock_divider_bank_if
//   Configuration bus for clock_divider_bank.
//
//   Handshake: cfg_we is a one-cycle valid strobe qualifying cfg_ch and
//   cfg_half. There is no ready; every strobe is accepted on the edge it is
//   sampled. cfg_busy is status only and never stalls the master. A set bit
//   means that channel holds a pending value that has not been applied yet.
//
//   Signals
//     cfg_we    master->slave  write strobe
//     cfg_ch    master->slave  target channel
//     cfg_half  master->slave  new half-period (0 stops the channel)
//     cfg_busy  slave->master  per-channel pending flag
// ---------------------------------------------------------------------------
interface clock_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] cfg_busy;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_half,
    input  cfg_busy
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_half,
    output cfg_busy
  );
endinterface

// File: rtl/clock_divider_bank.sv
// ---------------------------------------------------------------------------
// clock_divider_bank
//   NUM_CH independent programmable clock dividers running from one input
//   clock. Each channel emits a 50%-duty divided clock and a one-cycle tick
//   on that clock's rising edge. A new half-period is held as pending and is
//   only applied at the end of a full output period (the 1->0 toggle), or on
//   the next edge if the channel is stopped, so no period is ever cut short.
//
//   Ports
//     clock_in   in   input clock, all logic on its rising edge
//     reset_n    in   asynchronous active-low reset
//     enable     in   global run; low freezes counters and outputs
//     cfg        if   configuration bus (slave side, see the interface file)
//     clock_out  out  divided clocks, one per channel, registered
//     tick       out  one-cycle pulse coincident with clock_out 0->1
// ---------------------------------------------------------------------------
module clock_divider_bank #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 2
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 enable,
  clock_divider_bank_if.slave  cfg,
  output logic [NUM_CH-1:0]    clock_out,
  output logic [NUM_CH-1:0]    tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             busy_q;

    logic wr_hit;
    logic running;
    logic at_end;
    logic apply_now;

    // Addresses at or above NUM_CH match no channel, so such writes fall
    // through without touching any state.
    assign wr_hit  = cfg.cfg_we && (cfg.cfg_ch == CH_W'(ch));
    assign running = (half_q != '0);
    assign at_end  = (cnt_q == half_q - CNT_W'(1));

    // A pending value lands either at the end of the high phase (so the
    // period is complete) or straight away when the channel is stopped.
    assign apply_now = enable && busy_q && (!running || (at_end && clk_q));

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        half_q <= CNT_W'(DEFAULT_HALF);
        pend_q <= '0;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;

        if (enable) begin
          if (apply_now) begin
            half_q <= pend_q;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
          end else if (running) begin
            if (at_end) begin
              cnt_q  <= '0;
              clk_q  <= ~clk_q;
              tick_q <= ~clk_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        // A write on the apply edge wins the busy flag: the old pending has
        // just been consumed above and the new value takes its place.
        if (wr_hit) begin
          pend_q <= cfg.cfg_half;
          busy_q <= 1'b1;
        end else if (apply_now) begin
          busy_q <= 1'b0;
        end
      end
    end

    assign clock_out[ch]    = clk_q;
    assign tick[ch]         = tick_q;
    assign cfg.cfg_busy[ch] = busy_q;
  end

endmodule
